// File: rtl/parking_pkg.sv
// Shared constants and types for the parking path tracker: route codes,
// junction direction codes and the tracker state encoding.
package parking_pkg;

  localparam int unsigned NUM_BLOCKS = 7;

  typedef enum logic [1:0] {
    DIR_ILLEGAL = 2'b00,
    DIR_1       = 2'b01,
    DIR_2       = 2'b10,
    DIR_3       = 2'b11
  } dir_e;

  localparam logic [7:0] PATH_B0 = 8'b1111_1000;
  localparam logic [7:0] PATH_B1 = 8'b1111_0000;
  localparam logic [7:0] PATH_B2 = 8'b1101_0000;
  localparam logic [7:0] PATH_B3 = 8'b1101_1100;
  localparam logic [7:0] PATH_B4 = 8'b1100_0000;
  localparam logic [7:0] PATH_B5 = 8'b1101_0000;
  localparam logic [7:0] PATH_B6 = 8'b1101_0100;

  localparam logic [7:0] PATH_CODE [NUM_BLOCKS] = '{
    PATH_B0, PATH_B1, PATH_B2, PATH_B3, PATH_B4, PATH_B5, PATH_B6
  };

  localparam logic [2:0] NO_BLOCK = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_DECODE = 2'd2
  } state_e;

endpackage

// File: rtl/path_tracker_if.sv
// Sensor-side and controller-side signals of the path tracker.
interface path_tracker_if;
  import parking_pkg::*;

  logic                  entry;
  logic                  hop_valid;
  logic [1:0]            hop_dir;
  logic                  hop_last;
  logic                  exit_valid;
  logic [2:0]            exit_block;
  logic                  busy;
  logic                  block_valid;
  logic [2:0]            block_id;
  logic [7:0]            path_out;
  logic                  error;
  logic [NUM_BLOCKS-1:0] occupied;
  logic                  full;

  modport master (
    output entry, hop_valid, hop_dir, hop_last, exit_valid, exit_block,
    input  busy, block_valid, block_id, path_out, error, occupied, full
  );

  modport slave (
    input  entry, hop_valid, hop_dir, hop_last, exit_valid, exit_block,
    output busy, block_valid, block_id, path_out, error, occupied, full
  );
endinterface

// File: rtl/path_decode.sv
// Combinational route decoder: picks the lowest-index free block whose code
// matches the assembled path word.
module path_decode
  import parking_pkg::*;
(
  input  logic [7:0]            path,
  input  logic [NUM_BLOCKS-1:0] occ,
  output logic                  hit,
  output logic [2:0]            blockIdx
);

  always_comb begin
    hit      = 1'b0;
    blockIdx = '0;
    for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
      if (!hit && (path == PATH_CODE[i]) && !occ[i]) begin
        hit      = 1'b1;
        blockIdx = 3'(i);
      end
    end
  end

endmodule

// File: rtl/path_tracker.sv
// Tracks a car through the junctions, rebuilds its path word and decodes it
// to a parking block while maintaining the occupancy map.
module path_tracker
  import parking_pkg::*;
#(
  parameter int unsigned MAX_HOPS = 3,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  path_tracker_if.slave bus
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned HW = $clog2(MAX_HOPS + 1);

  state_e                state;
  logic [7:0]            pathReg;
  logic [HW-1:0]         hopCnt;
  logic [TW-1:0]         timer;
  logic                  busyR;
  logic                  blockValidR;
  logic                  errorR;
  logic [2:0]            blockIdR;
  logic [NUM_BLOCKS-1:0] occ;
  logic                  fullR;

  logic [NUM_BLOCKS-1:0] occCleared;
  logic [NUM_BLOCKS-1:0] occNext;
  logic                  hit;
  logic [2:0]            hitIdx;

  // Exit clear is folded in before decode so a same-cycle clear/set of one bit ends set.
  always_comb begin
    occCleared = occ;
    if (bus.exit_valid && (bus.exit_block != NO_BLOCK))
      occCleared[bus.exit_block] = 1'b0;
    occNext = occCleared;
    if ((state == ST_DECODE) && hit)
      occNext[hitIdx] = 1'b1;
  end

  path_decode uDecode (
    .path     (pathReg),
    .occ      (occCleared),
    .hit      (hit),
    .blockIdx (hitIdx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pathReg     <= '0;
      hopCnt      <= '0;
      timer       <= '0;
      busyR       <= 1'b0;
      blockValidR <= 1'b0;
      errorR      <= 1'b0;
      blockIdR    <= '0;
      occ         <= '0;
      fullR       <= 1'b0;
    end else begin
      blockValidR <= 1'b0;
      errorR      <= 1'b0;
      occ         <= occNext;
      fullR       <= &occNext;
      case (state)
        ST_IDLE: begin
          if (bus.entry) begin
            pathReg <= '0;
            hopCnt  <= '0;
            timer   <= '0;
            busyR   <= 1'b1;
            state   <= ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (bus.hop_valid) begin
            if ((bus.hop_dir == DIR_ILLEGAL) || (hopCnt == HW'(MAX_HOPS))) begin
              errorR <= 1'b1;
              busyR  <= 1'b0;
              state  <= ST_IDLE;
            end else begin
              // Hop k lands in bits [7-2k:6-2k]; those bits were zeroed at entry.
              pathReg <= pathReg | ({bus.hop_dir, 6'b0} >> {hopCnt, 1'b0});
              hopCnt  <= hopCnt + HW'(1);
              timer   <= '0;
              if (bus.hop_last)
                state <= ST_DECODE;
            end
          end else if (timer == TW'(TIMEOUT - 1)) begin
            errorR <= 1'b1;
            busyR  <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_DECODE: begin
          busyR <= 1'b0;
          state <= ST_IDLE;
          if (hit) begin
            blockValidR <= 1'b1;
            blockIdR    <= hitIdx;
          end else begin
            errorR <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy        = busyR;
  assign bus.block_valid = blockValidR;
  assign bus.block_id    = blockIdR;
  assign bus.path_out    = pathReg;
  assign bus.error       = errorR;
  assign bus.occupied    = occ;
  assign bus.full        = fullR;

endmodule

// File: tb/tb_path_tracker.sv
// Directed bench for path_tracker: expected decode/error results are queued
// when a route is driven and compared when the DUT pulses its outputs.
module tb_path_tracker;

  typedef struct {
    logic       err;
    logic [2:0] id;
    logic [6:0] occ;
    logic [7:0] path;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  path_tracker_if bus ();

  path_tracker #(.MAX_HOPS(3), .TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [7:0] CODES [7] = '{8'hF8, 8'hF0, 8'hD0, 8'hDC, 8'hC0, 8'hD0, 8'hD4};

  int checks = 0;
  int errors = 0;
  int nPulse = 0;
  int nExp   = 0;
  exp_t sb[$];

  logic [6:0] mOcc  = '0;
  logic [2:0] mId   = '0;
  logic [7:0] mPath = '0;
  int         mHops = 0;

  always @(negedge clk)
    if (rst_n && (bus.block_valid === 1'b1 || bus.error === 1'b1)) nPulse++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=hang expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushErr();
    exp_t e;
    e.err = 1'b1; e.id = mId; e.occ = mOcc; e.path = mPath;
    sb.push_back(e);
  endtask

  task automatic predictDecode(input logic exEn, input logic [2:0] exBlk);
    exp_t e;
    logic [6:0] o;
    o = mOcc;
    if (exEn && exBlk != 3'd7) o[exBlk] = 1'b0;
    e.err = 1'b1;
    for (int i = 0; i < 7; i++)
      if (e.err && CODES[i] == mPath && !o[i]) begin
        e.err = 1'b0;
        mId = 3'(i);
        o[i] = 1'b1;
      end
    mOcc = o;
    e.id = mId; e.occ = mOcc; e.path = mPath;
    sb.push_back(e);
  endtask

  task automatic checkOut(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=output expected=queued_result", tag);
      return;
    end
    e = sb.pop_front();
    nExp++;
    chk({tag, "_valid"}, bus.block_valid, !e.err);
    chk({tag, "_error"}, bus.error, e.err);
    chk({tag, "_id"}, bus.block_id, e.id);
    chk({tag, "_occ"}, bus.occupied, e.occ);
    chk({tag, "_full"}, bus.full, &e.occ);
    chk({tag, "_path"}, bus.path_out, e.path);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic startRoute();
    bus.entry = 1'b1;
    tick();
    bus.entry = 1'b0;
    mPath = '0;
    mHops = 0;
    chk("busy_after_entry", bus.busy, 1);
  endtask

  task automatic hop(input logic [1:0] dir, input logic last);
    bus.hop_valid = 1'b1; bus.hop_dir = dir; bus.hop_last = last;
    tick();
    bus.hop_valid = 1'b0; bus.hop_dir = 2'b00; bus.hop_last = 1'b0;
    if (dir == 2'b00 || mHops == 3) begin
      pushErr();
    end else begin
      mPath = mPath | (8'(dir) << (6 - 2 * mHops));
      mHops++;
      chk("path_after_hop", bus.path_out, mPath);
    end
  endtask

  task automatic finishRoute(input logic exEn, input logic [2:0] exBlk, input string tag);
    predictDecode(exEn, exBlk);
    bus.exit_valid = exEn; bus.exit_block = exBlk;
    @(posedge clk);
    #1;
    bus.exit_valid = 1'b0; bus.exit_block = 3'd0;
    @(negedge clk);
    checkOut(tag);
  endtask

  task automatic exitBlock(input logic [2:0] b);
    bus.exit_valid = 1'b1; bus.exit_block = b;
    tick();
    bus.exit_valid = 1'b0; bus.exit_block = 3'd0;
    if (b != 3'd7) mOcc[b] = 1'b0;
    chk("occ_after_exit", bus.occupied, mOcc);
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_valid"}, bus.block_valid, 0);
    chk({tag, "_error"}, bus.error, 0);
    chk({tag, "_full"}, bus.full, 0);
    chk({tag, "_id"}, bus.block_id, 0);
    chk({tag, "_path"}, bus.path_out, 0);
    chk({tag, "_occ"}, bus.occupied, 0);
  endtask

  initial begin
    logic [7:0] fillCode [7];
    int         fillHops [7];
    logic [7:0] code;

    fillCode = '{8'hF8, 8'hF0, 8'hD0, 8'hDC, 8'hC0, 8'hD0, 8'hD4};
    fillHops = '{3, 2, 2, 3, 1, 2, 3};

    bus.entry = 1'b0; bus.hop_valid = 1'b0; bus.hop_dir = 2'b00; bus.hop_last = 1'b0;
    bus.exit_valid = 1'b0; bus.exit_block = 3'd0;
    #12;
    checkAllZero("reset");
    rst_n = 1'b1;
    tick();

    // Single hop 11 decodes to block 4
    startRoute(); hop(2'b11, 1'b1); finishRoute(1'b0, 3'd0, "blk4");
    exitBlock(3'd4);

    // Duplicate code: block 2, block 5, then no free match
    repeat (3) begin
      startRoute(); hop(2'b11, 1'b0); hop(2'b01, 1'b1); finishRoute(1'b0, 3'd0, "dup");
    end
    exitBlock(3'd7);

    // Illegal direction, then hops ignored in IDLE
    startRoute(); hop(2'b11, 1'b0); hop(2'b00, 1'b0);
    @(negedge clk);
    checkOut("illegal_dir");
    bus.hop_valid = 1'b1; bus.hop_dir = 2'b11; bus.hop_last = 1'b1;
    tick();
    bus.hop_valid = 1'b0; bus.hop_dir = 2'b00; bus.hop_last = 1'b0;
    chk("idle_hop_busy", bus.busy, 0);
    chk("idle_hop_path", bus.path_out, mPath);

    // Fourth hop exceeds MAX_HOPS
    startRoute(); hop(2'b11, 1'b0); hop(2'b01, 1'b0); hop(2'b10, 1'b0); hop(2'b11, 1'b0);
    @(negedge clk);
    checkOut("max_hops");

    // Timeout after 8 idle cycles
    startRoute();
    repeat (7) tick();
    chk("timeout_early_error", bus.error, 0);
    chk("timeout_early_busy", bus.busy, 1);
    pushErr();
    @(posedge clk);
    @(negedge clk);
    checkOut("timeout");

    // Same-cycle exit and decode of block 3
    startRoute(); hop(2'b11, 1'b0); hop(2'b01, 1'b0); hop(2'b11, 1'b1);
    finishRoute(1'b0, 3'd0, "blk3");
    startRoute(); hop(2'b11, 1'b0); hop(2'b01, 1'b0); hop(2'b11, 1'b1);
    finishRoute(1'b1, 3'd3, "blk3_exit");

    // Reset in TRACK clears everything at once
    startRoute(); hop(2'b11, 1'b0);
    rst_n = 1'b0;
    #1;
    checkAllZero("midreset");
    mOcc = '0; mId = '0; mPath = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Fill every block, starting with route 11,11,10 -> block 0
    for (int r = 0; r < 7; r++) begin
      code = fillCode[r];
      startRoute();
      for (int j = 0; j < fillHops[r]; j++)
        hop(code[7 - 2 * j -: 2], (j == fillHops[r] - 1));
      finishRoute(1'b0, 3'd0, "fill");
    end
    chk("full_set", bus.full, 1);

    // Entry accepted while full; error at decode
    startRoute(); hop(2'b11, 1'b1); finishRoute(1'b0, 3'd0, "full_err");

    tick();
    chk("pulse_count", nPulse, nExp);
    chk("queue_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
